// File: rtl/avr_pkg.sv
// Shared AVR fetch definitions: two-word opcode patterns and the prefetch entry type.
package avr_pkg;

  localparam int AVR_PC_MAX = 32;

  localparam logic [15:0] LDS_MASK   = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH  = 16'h9000;
  localparam logic [15:0] STS_MASK   = 16'hFE0F;
  localparam logic [15:0] STS_MATCH  = 16'h9200;
  localparam logic [15:0] JMP_MASK   = 16'hFE0E;
  localparam logic [15:0] JMP_MATCH  = 16'h940C;
  localparam logic [15:0] CALL_MASK  = 16'hFE0E;
  localparam logic [15:0] CALL_MATCH = 16'h940E;

  // pc is sized for the widest supported program space; narrower units zero-extend
  typedef struct packed {
    logic [15:0]           word;
    logic [AVR_PC_MAX-1:0] pc;
  } fetch_ent_t;

  function automatic logic is_two_word(input logic [15:0] w);
    return ((w & LDS_MASK)  == LDS_MATCH)  ||
           ((w & STS_MASK)  == STS_MATCH)  ||
           ((w & JMP_MASK)  == JMP_MATCH)  ||
           ((w & CALL_MASK) == CALL_MATCH);
  endfunction

endpackage

// File: rtl/avr_fetch_queue.sv
// Circular prefetch buffer: single-word push, 0/1/2-entry pop, two head read ports.
module avr_fetch_queue
  import avr_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  fetch_ent_t push_ent,
  input  logic [1:0] pop,
  output fetch_ent_t head0,
  output fetch_ent_t head1,
  output logic [AW:0] level
);

  localparam int LW = AW + 1;

  fetch_ent_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign head0 = mem[rd_ptr];
  assign head1 = mem[rd_ptr + AW'(1)];

  // flush drops everything, including a same-cycle push
  always_ff @(posedge CLK) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level + LW'(push) - LW'(pop);
    end
  end

endmodule

// File: rtl/avr_fetch_unit.sv
// AVR instruction fetch stage: program-memory fetcher, prefetch queue, two-word packet issue.
module avr_fetch_unit
  import avr_pkg::*;
#(
  parameter  int                 PADDR_W   = 16,
  parameter  int                 DEPTH     = 4,
  parameter  logic [PADDR_W-1:0] RESET_VEC = '0,
  localparam int                 LW        = $clog2(DEPTH) + 1
) (
  input  logic               CLK,
  input  logic               RST,
  output logic [PADDR_W-1:0] p_addr,
  output logic               p_rd,
  input  logic [15:0]        p_data,
  output logic [15:0]        instr,
  output logic [15:0]        instr_ext,
  output logic [PADDR_W-1:0] instr_pc,
  output logic               instr_two,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redir,
  input  logic [PADDR_W-1:0] redir_pc,
  output logic [LW-1:0]      q_level
);

  localparam int SW = LW + 1;

  logic [PADDR_W-1:0] fetch_pc, pend_pc;
  logic               pending;
  fetch_ent_t         head0, head1, push_ent;
  logic               head_two, fire;
  logic [1:0]         pop;
  logic               unused_pc;

  // the in-flight word counts against capacity so its return always has a slot
  assign p_addr = fetch_pc;
  assign p_rd   = RST && !redir && ((SW'(q_level) + SW'(pending)) < SW'(DEPTH));

  assign push_ent.word = p_data;
  assign push_ent.pc   = AVR_PC_MAX'(pend_pc);

  assign head_two    = is_two_word(head0.word);
  assign instr_valid = (q_level != '0) && (!head_two || q_level >= LW'(2));
  assign fire        = instr_valid && instr_ready;
  assign pop         = fire ? (head_two ? 2'd2 : 2'd1) : 2'd0;

  assign instr     = instr_valid ? head0.word : '0;
  assign instr_ext = (instr_valid && head_two) ? head1.word : '0;
  assign instr_pc  = instr_valid ? head0.pc[PADDR_W-1:0] : '0;
  assign instr_two = instr_valid && head_two;
  assign unused_pc = ^{head0.pc, head1.pc};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      fetch_pc <= RESET_VEC;
      pend_pc  <= RESET_VEC;
      pending  <= 1'b0;
    end else if (redir) begin
      fetch_pc <= redir_pc;
      pending  <= 1'b0;
    end else begin
      pending <= p_rd;
      if (p_rd) begin
        fetch_pc <= fetch_pc + PADDR_W'(1);
        pend_pc  <= fetch_pc;
      end
    end
  end

  avr_fetch_queue #(.DEPTH(DEPTH)) u_q (
    .CLK      (CLK),
    .rst_n    (RST),
    .flush    (redir),
    .push     (pending),
    .push_ent (push_ent),
    .pop      (pop),
    .head0    (head0),
    .head1    (head1),
    .level    (q_level)
  );

endmodule

// File: tb/tb_avr_fetch_unit.sv
// Scoreboard bench for avr_fetch_unit: memory model answers p_rd, packets checked in issue order.
module tb_avr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] p_addr;
  logic        p_rd;
  logic [15:0] p_data;
  logic [15:0] instr, instr_ext, instr_pc;
  logic        instr_two, instr_valid, instr_ready;
  logic        redir;
  logic [15:0] redir_pc;
  logic [2:0]  q_level;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] w;
    logic [15:0] ext;
    logic [15:0] pc;
    logic        two;
  } pkt_t;

  pkt_t sb[$];

  always #5 CLK = ~CLK;

  avr_fetch_unit #(.PADDR_W(16), .DEPTH(4), .RESET_VEC(16'h0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .p_addr      (p_addr),
    .p_rd        (p_rd),
    .p_data      (p_data),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_pc    (instr_pc),
    .instr_two   (instr_two),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redir       (redir),
    .redir_pc    (redir_pc),
    .q_level     (q_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h50A1;
      16'h0001: return 16'h50A2;
      16'h0002: return 16'h50A0;
      16'h0004: return 16'h940C;
      16'h0005: return 16'h0123;
      16'h0201: return 16'h940E;
      16'h0202: return 16'h4567;
      16'hFFFF: return 16'h9300;
      default:  return {4'h1, a[11:0]};
    endcase
  endfunction

  function automatic logic ref_two(input logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  // expected packet stream from a start address, wrapping at 16 bits
  task automatic sb_load(input logic [15:0] start);
    logic [15:0] pc;
    pkt_t        p;
    sb.delete();
    pc = start;
    for (int i = 0; i < 96; i++) begin
      p.w   = mem_rd(pc);
      p.two = ref_two(p.w);
      p.ext = p.two ? mem_rd(pc + 16'd1) : 16'h0000;
      p.pc  = pc;
      sb.push_back(p);
      pc = pc + (p.two ? 16'd2 : 16'd1);
    end
  endtask

  task automatic step();
    logic        rd;
    logic [15:0] a;
    pkt_t        e;
    @(negedge CLK);
    rd = p_rd;
    a  = p_addr;
    if (instr_valid && instr_ready) begin
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pkt_w",   instr,     e.w);
        chk("pkt_ext", instr_ext, e.ext);
        chk("pkt_pc",  instr_pc,  e.pc);
        chk("pkt_two", instr_two, e.two);
      end
    end
    @(posedge CLK);
    #1;
    p_data = rd ? mem_rd(a) : 16'hDEAD;
  endtask

  initial begin
    int n;
    int sz0;
    RST = 1'b0; instr_ready = 1'b1; redir = 1'b0; redir_pc = '0; p_data = '0;
    repeat (3) step();
    chk("rst_prd",   p_rd,        0);
    chk("rst_paddr", p_addr,      0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_lvl",   q_level,     0);
    chk("rst_instr", instr,       0);
    chk("rst_ext",   instr_ext,   0);
    chk("rst_pc",    instr_pc,    0);
    chk("rst_two",   instr_two,   0);

    // startup latency and back-to-back single-word issue
    sb_load(16'h0000);
    RST = 1'b1;
    #1;
    chk("first_prd",   p_rd,   1);
    chk("first_paddr", p_addr, 0);
    step(); chk("lat1_valid", instr_valid, 0);
    step(); chk("lat2_valid", instr_valid, 1); chk("lat2_instr", instr, 16'h50A1);
    step(); chk("seq1_valid", instr_valid, 1); chk("seq1_instr", instr, 16'h50A2);
    step(); chk("seq2_valid", instr_valid, 1); chk("seq2_instr", instr, 16'h50A0);
    repeat (12) step();

    // consumer stall: queue fills, fetch stops, head held
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_valid", instr_valid, 1);
      chk("stall_instr", instr,       sb[0].w);
      chk("stall_pc",    instr_pc,    sb[0].pc);
    end
    chk("stall_lvl", q_level, 4);
    chk("stall_prd", p_rd,    0);
    instr_ready = 1'b1;
    sz0 = sb.size();
    repeat (20) step();
    chk("stall_resume", (sz0 - sb.size()) >= 15, 1);

    // redirect with three queued words and one in flight
    instr_ready = 1'b0;
    n = 0;
    while (!(q_level == 3 && !p_rd) && n < 20) begin step(); n++; end
    chk("wait_lvl3", n < 20, 1);
    redir = 1'b1; redir_pc = 16'h0200;
    #1;
    chk("redir_prd", p_rd, 0);
    step();
    redir = 1'b0;
    sb_load(16'h0200);
    #1;
    chk("post_redir_prd",  p_rd,        1);
    chk("post_redir_addr", p_addr,      16'h0200);
    chk("post_redir_lvl",  q_level,     0);
    chk("post_redir_v0",   instr_valid, 0);
    step();
    chk("post_redir_v1",   instr_valid, 0);
    instr_ready = 1'b1;
    repeat (20) step();

    // redirect coinciding with acceptance of the packet at pc 8
    redir = 1'b1; redir_pc = 16'h0006;
    step();
    redir = 1'b0;
    sb_load(16'h0006);
    n = 0;
    while (!(instr_valid && instr_pc == 16'h0008) && n < 20) begin step(); n++; end
    chk("wait_pc8", n < 20, 1);
    redir = 1'b1; redir_pc = 16'h0040;
    sz0 = sb.size();
    step();
    chk("pc8_taken", sz0 - sb.size(), 1);
    redir = 1'b0;
    sb_load(16'h0040);
    repeat (10) step();

    // back-to-back redirects: last target wins
    redir = 1'b1; redir_pc = 16'h0100;
    step();
    redir_pc = 16'h0080;
    step();
    redir = 1'b0;
    sb_load(16'h0080);
    #1;
    chk("b2b_addr", p_addr, 16'h0080);
    repeat (10) step();

    // two-word instruction straddling the top of the address space
    redir = 1'b1; redir_pc = 16'hFFFE;
    step();
    redir = 1'b0;
    sb_load(16'hFFFE);
    sz0 = sb.size();
    repeat (12) step();
    chk("wrap_progress", (sz0 - sb.size()) >= 4, 1);

    // reset while busy
    instr_ready = 1'b0;
    repeat (3) step();
    RST = 1'b0;
    step();
    chk("mid_rst_lvl",   q_level,     0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_addr",  p_addr,      0);
    RST = 1'b1;
    instr_ready = 1'b1;
    sb_load(16'h0000);
    sz0 = sb.size();
    repeat (15) step();
    chk("mid_rst_resume", (sz0 - sb.size()) >= 8, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
